// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte FIFO between a UART receiver and a pushbutton-driven LED/display readout.
// Latency: a push into an empty FIFO shows on out_data the next cycle; a button press pops two edges after it is first sampled low.
// Backpressure: none upstream; a byte that arrives while full, with no pop in the same cycle, is dropped and latches the sticky overflow flag.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   wr_valid, wr_data   - one-cycle byte strobe and data from the receiver
//   rd_btn              - asynchronous active-low pop pushbutton (idle 1)
//   out_data, out_valid - head entry (zero when empty) and non-empty flag
//   count, full         - stored entry count (0..DEPTH) and full flag
//   overflow            - sticky dropped-byte flag, cleared only by rst
module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_btn,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  // Button synchronizer (s1, s2) plus history flop s3 for falling-edge detect.
  logic s1, s2, s3;
  // post: at least one real button sample has landed in s1 since reset.
  // armed: the button has been seen released since reset, so a press held
  // across reset release cannot masquerade as a new press.
  logic post;
  logic armed;

  logic pop_req;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign pop_req = armed & s3 & ~s2;
  assign pop_ok  = pop_req & (count != '0);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = wr_valid & (~full | pop_ok);
  assign drop    = wr_valid & full & ~pop_ok;

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign out_data  = out_valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      post     <= 1'b0;
      armed    <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s1    <= rd_btn;
      s2    <= s1;
      s3    <= s2;
      post  <= 1'b1;
      armed <= armed | (post & s1);

      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop_ok) begin
        rp <= rp + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; out_data masks it to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wp] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed bench for rx_byte_fifo with DEPTH=8, WIDTH=8.
// Inputs are driven 1 ns after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants in each directed step.
module tb_rx_byte_fifo;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_btn;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] count;
  logic       full;
  logic       overflow;

  int checks;
  int errors;

  rx_byte_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .rd_btn   (rd_btn),
    .out_data (out_data),
    .out_valid(out_valid),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    wr_data  = 8'h00;
  endtask

  // Press: pop lands on the third edge; release and let the synchronizer settle.
  task automatic pop();
    rd_btn = 1'b0;
    repeat (3) step();
    rd_btn = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_btn   = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);

    // Single push then timed pop
    push(8'h14);
    chk("p1_data", out_data, 8'h14);
    chk("p1_valid", out_valid, 1);
    chk("p1_count", count, 1);
    rd_btn = 1'b0;
    step();
    chk("pop_edgeN_count", count, 1);
    step();
    chk("pop_edgeN1_count", count, 1);
    step();
    chk("pop_edgeN2_count", count, 0);
    chk("pop_edgeN2_data", out_data, 8'h00);
    chk("pop_edgeN2_valid", out_valid, 0);
    rd_btn = 1'b1;
    repeat (3) step();

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf", overflow, 0);
    push(8'h09);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", out_data, i);
      pop();
    end
    chk("drain_count", count, 0);
    chk("drain_ovf_sticky", overflow, 1);
    chk("drain_data", out_data, 0);

    // Pointer wrap
    do_reset();
    chk("wrap_rst_ovf", overflow, 0);
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 1; i <= 3; i++) begin
      chk("wrap_head_a", out_data, i);
      pop();
    end
    chk("wrap_count5", count, 5);
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    chk("wrap_count8", count, 8);
    chk("wrap_ovf", overflow, 0);
    for (int i = 4; i <= 8; i++) begin
      chk("wrap_head_b", out_data, i);
      pop();
    end
    for (int i = 0; i <= 2; i++) begin
      chk("wrap_head_c", out_data, 8'hA0 + 8'(i));
      pop();
    end
    chk("wrap_empty", count, 0);

    // Push coincident with pop while full
    for (int i = 1; i <= 8; i++) push(8'(i));
    rd_btn = 1'b0;
    step();
    step();
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    step();
    wr_valid = 1'b0;
    chk("coinc_count", count, 8);
    chk("coinc_ovf", overflow, 0);
    chk("coinc_full", full, 1);
    chk("coinc_head", out_data, 8'h02);
    rd_btn = 1'b1;
    repeat (3) step();
    for (int i = 2; i <= 8; i++) begin
      chk("coinc_drain", out_data, i);
      pop();
    end
    chk("coinc_last", out_data, 8'h55);
    pop();
    chk("coinc_empty", count, 0);

    // Long hold gives one pop; pop on empty is ignored
    push(8'h31);
    push(8'h32);
    push(8'h33);
    rd_btn = 1'b0;
    repeat (200) step();
    chk("hold_count", count, 2);
    chk("hold_head", out_data, 8'h32);
    rd_btn = 1'b1;
    repeat (3) step();
    pop();
    pop();
    chk("hold_drained", count, 0);
    pop();
    chk("empty_pop_count", count, 0);
    chk("empty_pop_valid", out_valid, 0);
    chk("empty_pop_ovf", overflow, 0);

    // Reset mid-operation with button held low
    for (int i = 1; i <= 8; i++) push(8'h60 + 8'(i));
    push(8'h6F);
    chk("mid_ovf_set", overflow, 1);
    pop();
    pop();
    pop();
    chk("mid_count5", count, 5);
    rd_btn   = 1'b0;
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    step();
    wr_valid = 1'b0;
    step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst = 1'b0;
    push(8'h77);
    chk("post_rst_head", out_data, 8'h77);
    repeat (10) step();
    chk("held_no_pop", count, 1);
    rd_btn = 1'b1;
    repeat (3) step();
    chk("release_no_pop", count, 1);
    pop();
    chk("repress_pop", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of byte entries; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: one-cycle strobe from the UART receiver marking a completed byte.
REQ-006 The block SHALL have port wr_data, input, WIDTH bits: the received byte, qualified by wr_valid.
REQ-007 The block SHALL have port rd_btn, input, 1 bit: asynchronous active-low pushbutton requesting a pop; idle level is 1.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: the head entry, driven to the LEDs.
REQ-009 The block SHALL have port out_valid, output, 1 bit: high when the FIFO holds at least one entry.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of stored entries, 0..DEPTH, driven to the display.
REQ-011 The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-013 rd_btn SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; a pop request exists in a cycle where s3=1 and s2=0.
REQ-014 When rd_btn is first sampled low at rising edge N and held, the pop SHALL take effect at edge N+2; holding the button low SHALL yield exactly one pop.
REQ-015 Storage SHALL be a DEPTH x WIDTH register array, with write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH with no special-case logic.
REQ-016 Push: when wr_valid=1 and full=0, mem[wp] <= wr_data, wp increments, and count increments, all at that edge.
REQ-017 Drop: when wr_valid=1 and full=1 with no pop in the same cycle, the byte SHALL be discarded, the pointers and count left unchanged, and overflow set to 1 at that edge.
REQ-018 Pop: when a pop request exists and count>0, rp increments and count decrements at that edge; a pop with count=0 SHALL be ignored with no flag.
REQ-019 Simultaneous push and pop with 0<count<DEPTH: both SHALL occur and count is unchanged.
REQ-020 Simultaneous push and pop with count=DEPTH: the pop SHALL free the slot, the push SHALL be accepted into it, count stays DEPTH, and overflow is not set.
REQ-021 Simultaneous push and pop with count=0: the push SHALL be accepted, the pop ignored, and count becomes 1.
REQ-022 out_data SHALL equal mem[rp] when count>0 and all-zeros when count=0 (first-word fall-through); a pushed byte appears on out_data the cycle after its wr_valid edge if the FIFO was empty.
REQ-023 out_valid SHALL equal (count!=0), and full SHALL equal (count==DEPTH); both are derived only from registered count.
REQ-024 overflow SHALL remain 1 until rst, independent of later pops.
REQ-025 wr_valid held high for several cycles SHALL push once per cycle; de-duplicating strobes is the upstream block's responsibility.

Reset
REQ-026 While rst=1 at a rising edge: wp=0, rp=0, count=0, overflow=0, and s1=s2=s3=1.
REQ-027 After reset, out_data=0, out_valid=0, and full=0; memory contents are not cleared and are not observable.
REQ-028 Reset SHALL override any push or pop in the same cycle, and a button held low across reset release SHALL NOT generate a pop until it is released and pressed again.
REQ-029 A reset mid-operation SHALL discard all entries, and the next push SHALL appear at out_data as the head.

Verification
REQ-030 Reset, then push 0x14 -> the next cycle shows out_data=0x14, out_valid=1, count=1; press rd_btn -> 2 edges later count=0, out_data=0x00.
REQ-031 Push 0x01..0x08 (DEPTH=8) -> full=1, count=8; push 0x09 -> overflow=1, count=8; 8 pops -> out_data sequence 0x01..0x08, overflow still 1.
REQ-032 Fill, pop 3, push 0xA0..0xA2 (pointer wrap) -> pops yield 0x04..0x08 then 0xA0..0xA2.
REQ-033 With the FIFO full, a push of 0x55 coincident with the pop edge -> count stays 8, overflow stays 0, and 0x55 is the last entry popped.
REQ-034 Hold rd_btn low for 200 cycles with count=3 -> exactly one pop (count=2); pop with count=0 -> no change.
REQ-035 Assert rst with count=5 and rd_btn low -> count=0 and overflow=0, and no pop occurs after release until the button is re-pressed.
